// File: rtl/vibrometer_fft_pkg.sv
// Shared types for the FFT spectrum frame buffer: writer FSM states, bin layout
// and the bank selection helper.
package vibrometer_fft_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_WRITE, ST_DROP} fft_wr_state_t;

    localparam int FFT_RE_LSB = 0;
    localparam int FFT_IM_LSB = 16;

    typedef struct packed {
        logic signed [15:0] im;
        logic signed [15:0] re;
    } fft_bin_t;

    // Fill the bank the reader will see next unless it is already holding a frame.
    function automatic logic pick_bank(input logic [1:0] full, input logic oldest);
        return full[oldest] ? ~oldest : oldest;
    endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// The memory array itself is not reset; only the read register is.
module fft_frame_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_fft_frame_buffer.sv
// Captures whole FFT spectrum frames from an AXI-Stream into a ping-pong RAM
// for a PS-side reader; never back-pressures, drops frames when both banks are full.
module axis_fft_frame_buffer
    import vibrometer_fft_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned LOG_FRAME_LENGTH = 8,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    input  logic                        S_AXIS_tlast,
    output logic                        S_AXIS_tready,
    input  logic [LOG_FRAME_LENGTH-1:0] rd_addr,
    output logic [AXIS_TDATA_WIDTH-1:0] rd_data,
    output logic                        rd_valid,
    output logic                        rd_bank,
    input  logic                        rd_release,
    output logic                        frame_irq,
    output logic [CNT_WIDTH-1:0]        drop_count,
    output logic [CNT_WIDTH-1:0]        error_count
);

    localparam logic [LOG_FRAME_LENGTH-1:0] LAST_BIN = '1;

    fft_wr_state_t               state_q, state_d;
    logic [LOG_FRAME_LENGTH-1:0] bin_cnt_q, bin_cnt_d;
    logic                        wr_bank_q, wr_bank_d;
    logic [1:0]                  full_q, full_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]        drop_q, err_q;
    logic                        tready_q, irq_q;

    logic accepted, at_last, bank_done, release_ok;
    logic free_any, next_bank;
    logic drop_inc, err_inc, we;

    assign accepted   = S_AXIS_tvalid & tready_q;
    assign at_last    = (bin_cnt_q == LAST_BIN);
    assign bank_done  = (state_q == ST_WRITE) & enable & accepted & S_AXIS_tlast & at_last;
    assign release_ok = rd_release & full_q[rd_ptr_q];

    // Bank bookkeeping; a fill and a release in the same cycle both take effect.
    always_comb begin
        full_d   = full_q;
        rd_ptr_d = rd_ptr_q;
        if (release_ok) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
        if (bank_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
        free_any  = ~&full_d;
        next_bank = pick_bank(full_d, rd_ptr_d);
    end

    always_comb begin
        state_d   = state_q;
        bin_cnt_d = bin_cnt_q;
        wr_bank_d = wr_bank_q;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        we        = 1'b0;
        if (!enable) begin
            state_d   = ST_IDLE;
            bin_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: begin
                    if (accepted && S_AXIS_tlast) begin
                        state_d   = free_any ? ST_WRITE : ST_DROP;
                        wr_bank_d = next_bank;
                    end
                end
                ST_WRITE, ST_DROP: begin
                    if (accepted) begin
                        we = (state_q == ST_WRITE);
                        if (S_AXIS_tlast || at_last) begin
                            bin_cnt_d = '0;
                            if (!S_AXIS_tlast) begin
                                // Lost the frame boundary: resynchronise on the next tlast.
                                err_inc = 1'b1;
                                state_d = ST_SYNC;
                            end else begin
                                err_inc   = ~at_last;
                                drop_inc  = at_last & (state_q == ST_DROP);
                                state_d   = free_any ? ST_WRITE : ST_DROP;
                                wr_bank_d = next_bank;
                            end
                        end else begin
                            bin_cnt_d = bin_cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            bin_cnt_q <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            rd_ptr_q  <= 1'b0;
            drop_q    <= '0;
            err_q     <= '0;
            tready_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_cnt_q <= bin_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            rd_ptr_q  <= rd_ptr_d;
            tready_q  <= 1'b1;
            irq_q     <= bank_done;
            if (drop_inc && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
            if (err_inc && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    fft_frame_ram #(
        .DATA_WIDTH(AXIS_TDATA_WIDTH),
        .ADDR_WIDTH(LOG_FRAME_LENGTH + 1)
    ) u_ram (
        .clk  (aclk),
        .rst_n(aresetn),
        .we   (we),
        .waddr({wr_bank_q, bin_cnt_q}),
        .wdata(S_AXIS_tdata),
        .raddr({rd_ptr_q, rd_addr}),
        .rdata(rd_data)
    );

    assign S_AXIS_tready = tready_q;
    assign rd_valid      = full_q[rd_ptr_q];
    assign rd_bank       = rd_ptr_q;
    assign frame_irq     = irq_q;
    assign drop_count    = drop_q;
    assign error_count   = err_q;

endmodule

// File: tb/tb_axis_fft_frame_buffer.sv
// Directed bench for axis_fft_frame_buffer: table-driven read/release vectors
// plus hand-written sequences for sync, error, overlap and reset corners.
module tb_axis_fft_frame_buffer;

    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tlast;
    logic        S_AXIS_tready;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_bank;
    logic        rd_release;
    logic        frame_irq;
    logic [15:0] drop_count;
    logic [15:0] error_count;

    int errors = 0;
    int checks = 0;
    int irq_cnt = 0;
    int irq_base;
    int valid_gaps = 0;
    logic watch = 1'b0;

    axis_fft_frame_buffer dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .S_AXIS_tdata (S_AXIS_tdata),
        .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tlast (S_AXIS_tlast),
        .S_AXIS_tready(S_AXIS_tready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_bank      (rd_bank),
        .rd_release   (rd_release),
        .frame_irq    (frame_irq),
        .drop_count   (drop_count),
        .error_count  (error_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (frame_irq) irq_cnt++;
        if (watch && !rd_valid) valid_gaps++;
    end

    typedef struct packed {
        logic        rel;
        logic [7:0]  addr;
        logic        exp_valid;
        logic        exp_bank;
        logic [31:0] exp_data;
        logic        chk_data;
    } rd_vec_t;

    rd_vec_t vecs [9];

    // Frame f, bin k: re = 256*f + k, im = -re (frame 0 is the plain k/-k ramp).
    function automatic logic [31:0] bin_word(input int f, input int k);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'(f * 256 + k);
        im = ~re + 16'd1;
        return {im, re};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input logic rel);
        S_AXIS_tdata  = d;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tlast  = last;
        rd_release    = rel;
        tick();
        rd_release    = 1'b0;
    endtask

    task automatic send_frame(input int f, input int first, input int last_bin,
                              input logic with_tlast, input logic rel_on_last);
        for (int k = first; k <= last_bin; k++) begin
            send_beat(bin_word(f, k), with_tlast && (k == last_bin), rel_on_last && (k == last_bin));
        end
    endtask

    task automatic read_at(input string name, input int addr, input logic [31:0] exp);
        rd_addr = 8'(addr);
        tick();
        check(name, rd_data, exp);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd0,   1'b1, 1'b0, bin_word(0, 0),   1'b1};
        vecs[1] = '{1'b0, 8'd5,   1'b1, 1'b0, bin_word(0, 5),   1'b1};
        vecs[2] = '{1'b0, 8'd255, 1'b1, 1'b0, bin_word(0, 255), 1'b1};
        vecs[3] = '{1'b0, 8'd128, 1'b1, 1'b0, bin_word(0, 128), 1'b1};
        vecs[4] = '{1'b1, 8'd0,   1'b1, 1'b1, 32'd0,            1'b0};
        vecs[5] = '{1'b0, 8'd5,   1'b1, 1'b1, bin_word(1, 5),   1'b1};
        vecs[6] = '{1'b0, 8'd255, 1'b1, 1'b1, bin_word(1, 255), 1'b1};
        vecs[7] = '{1'b1, 8'd0,   1'b0, 1'b0, 32'd0,            1'b0};
        vecs[8] = '{1'b1, 8'd0,   1'b0, 1'b0, 32'd0,            1'b0};

        aresetn       = 1'b0;
        enable        = 1'b0;
        S_AXIS_tdata  = '0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        rd_addr       = '0;
        rd_release    = 1'b0;
        tick();
        tick();
        check("reset tready", 32'(S_AXIS_tready), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset drop_count", 32'(drop_count), 32'd0);
        check("reset error_count", 32'(error_count), 32'd0);
        aresetn = 1'b1;
        tick();
        check("tready after reset", 32'(S_AXIS_tready), 32'd1);

        // Three frames, no reads: two fill the banks, the third is dropped.
        enable   = 1'b1;
        idle(2);
        irq_base = irq_cnt;
        send_beat(32'd0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(f, 0, 255, 1'b1, 1'b0);
        idle(3);
        check("three frames irq", 32'(irq_cnt - irq_base), 32'd2);
        check("three frames drop", 32'(drop_count), 32'd1);
        check("three frames error", 32'(error_count), 32'd0);

        for (int i = 0; i < 9; i++) begin
            rd_release = vecs[i].rel;
            rd_addr    = vecs[i].addr;
            tick();
            rd_release = 1'b0;
            check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d rd_bank", i), 32'(rd_bank), 32'(vecs[i].exp_bank));
            if (vecs[i].chk_data) check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_data);
        end

        // Stream joins mid-frame after enable: only the frame after the first tlast lands.
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        idle(2);
        irq_base = irq_cnt;
        send_frame(3, 100, 255, 1'b1, 1'b0);
        send_frame(4, 0, 255, 1'b1, 1'b0);
        idle(3);
        check("midframe irq", 32'(irq_cnt - irq_base), 32'd1);
        check("midframe rd_valid", 32'(rd_valid), 32'd1);
        check("midframe rd_bank", 32'(rd_bank), 32'd0);
        read_at("midframe bin100", 100, bin_word(4, 100));
        read_at("midframe bin0", 0, bin_word(4, 0));
        send_beat(32'd0, 1'b0, 1'b1);
        idle(1);
        check("midframe released", 32'(rd_valid), 32'd0);

        // Early tlast at bin 10, then a good frame, then a frame with no tlast.
        irq_base = irq_cnt;
        send_frame(5, 0, 10, 1'b1, 1'b0);
        send_frame(6, 0, 255, 1'b1, 1'b0);
        idle(3);
        check("early tlast error", 32'(error_count), 32'd1);
        check("after early irq", 32'(irq_cnt - irq_base), 32'd1);
        check("after early rd_bank", 32'(rd_bank), 32'd1);
        read_at("after early bin10", 10, bin_word(6, 10));
        read_at("after early bin200", 200, bin_word(6, 200));
        send_frame(7, 0, 255, 1'b0, 1'b0);
        idle(3);
        check("missing tlast error", 32'(error_count), 32'd2);
        check("missing tlast irq", 32'(irq_cnt - irq_base), 32'd1);
        check("missing tlast rd_bank", 32'(rd_bank), 32'd1);

        // Fill bank 0 on the same cycle bank 1 is released.
        watch    = 1'b1;
        irq_base = irq_cnt;
        send_beat(32'd0, 1'b1, 1'b0);
        send_frame(8, 0, 255, 1'b1, 1'b1);
        idle(3);
        watch = 1'b0;
        check("overlap rd_valid gaps", 32'(valid_gaps), 32'd0);
        check("overlap irq", 32'(irq_cnt - irq_base), 32'd1);
        check("overlap rd_bank", 32'(rd_bank), 32'd0);
        check("overlap rd_valid", 32'(rd_valid), 32'd1);
        check("overlap drop", 32'(drop_count), 32'd1);
        read_at("overlap bin7", 7, bin_word(8, 7));

        // Reset in the middle of a frame.
        send_frame(9, 0, 127, 1'b0, 1'b0);
        S_AXIS_tdata = bin_word(9, 128);
        #2;
        aresetn       = 1'b0;
        S_AXIS_tvalid = 1'b0;
        #1;
        check("midreset tready", 32'(S_AXIS_tready), 32'd0);
        check("midreset rd_valid", 32'(rd_valid), 32'd0);
        check("midreset rd_bank", 32'(rd_bank), 32'd0);
        check("midreset frame_irq", 32'(frame_irq), 32'd0);
        check("midreset drop", 32'(drop_count), 32'd0);
        check("midreset error", 32'(error_count), 32'd0);
        check("midreset rd_data", rd_data, 32'd0);
        idle(2);
        aresetn = 1'b1;
        idle(3);
        irq_base = irq_cnt;
        send_beat(32'd0, 1'b1, 1'b0);
        send_frame(10, 0, 255, 1'b1, 1'b0);
        idle(3);
        check("post reset irq", 32'(irq_cnt - irq_base), 32'd1);
        check("post reset rd_valid", 32'(rd_valid), 32'd1);
        check("post reset rd_bank", 32'(rd_bank), 32'd0);
        read_at("post reset bin77", 77, bin_word(10, 77));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
